// File: rtl/mask_encoder16.sv
// Sequential mask-to-index encoder: accepts a request mask and streams the
// index of every set bit, lowest first, over a valid/ready handshake.
module mask_encoder16 #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_mask,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] pending_drop;
    logic             accept;
    logic             mask_nz;
    logic             beat;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
        lowest_set = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = IDX_W'(i);
            end
        end
    endfunction

    assign mask_nz      = (in_mask != '0);
    assign accept       = (state == IDLE) && in_valid;
    assign beat         = out_valid && out_ready;
    // v & (v - 1) clears the lowest set bit, i.e. the one out_idx points at
    assign pending_drop = pending & (pending - WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            zero_mask <= 1'b0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            zero_mask <= accept && !mask_nz;
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = pending;
        case (state)
            IDLE: begin
                if (accept && mask_nz) begin
                    state_next   = SCAN;
                    pending_next = in_mask;
                end
            end
            SCAN: begin
                if (beat) begin
                    pending_next = pending_drop;
                    if (out_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == SCAN);
        out_valid = (state == SCAN);
        out_idx   = lowest_set(pending);
        out_last  = (pending != '0) && (pending_drop == '0);
    end

endmodule

// File: tb/tb_mask_encoder16.sv
// Bench for mask_encoder16: directed table, hand sequences and random masks
// checked against a bit-list reference model and a decoder reconstruction.
module tb_mask_encoder16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        zero_mask;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mask_encoder16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_mask (zero_mask),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mask;
        int          beats;
        logic [3:0]  first;
        logic [3:0]  final_idx;
    } vec_t;

    vec_t tbl[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one mask, drain it with out_ready asserted with probability pct,
    // comparing every beat against the expected ascending list of set bits.
    task automatic run_mask(input logic [15:0] mask, input int pct,
                            output int nb, output logic [3:0] fi,
                            output logic [3:0] la, output int cyc);
        int          exp_q[$];
        logic [15:0] recon;
        int          budget;
        logic        r;
        nb = 0; fi = 0; la = 0; cyc = 0; recon = '0;
        budget = 0;
        while (!in_ready && budget < 50) begin
            step();
            budget++;
        end
        chk("in_ready_wait", in_ready, 1);
        for (int b = 0; b < 16; b++) if (mask[b]) exp_q.push_back(b);
        in_valid = 1'b1;
        in_mask  = mask;
        step();
        in_valid = 1'b0;
        in_mask  = $urandom;
        if (mask == 16'h0) begin
            chk("zero_pulse", zero_mask, 1);
            chk("zero_no_valid", out_valid, 0);
            chk("zero_in_ready", in_ready, 1);
            step();
            chk("zero_pulse_end", zero_mask, 0);
            chk("zero_no_valid2", out_valid, 0);
            return;
        end
        budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_busy", busy, 1);
            chk("beat_in_ready", in_ready, 0);
            chk("beat_zero", zero_mask, 0);
            chk("beat_idx", out_idx, exp_q[0]);
            chk("beat_last", out_last, exp_q.size() == 1);
            r = ($urandom_range(99) < pct);
            out_ready = r;
            if (r) begin
                if (nb == 0) fi = out_idx;
                la = out_idx;
                recon |= 16'h1 << out_idx;
                nb++;
                void'(exp_q.pop_front());
            end
            step();
            cyc++;
            budget++;
        end
        out_ready = 1'b0;
        chk("drain_bound", exp_q.size(), 0);
        chk("end_valid", out_valid, 0);
        chk("end_in_ready", in_ready, 1);
        chk("end_busy", busy, 0);
        chk("recon", recon, mask);
    endtask

    initial begin
        int          nb;
        int          cyc;
        logic [15:0] m;
        logic [3:0]  fi;
        logic [3:0]  la;

        tbl[0] = '{16'h0001, 1, 4'd0, 4'd0};
        tbl[1] = '{16'h8421, 4, 4'd0, 4'd15};
        tbl[2] = '{16'hFFFF, 16, 4'd0, 4'd15};
        tbl[3] = '{16'h0110, 2, 4'd4, 4'd8};
        tbl[4] = '{16'h8000, 1, 4'd15, 4'd15};
        tbl[5] = '{16'h00F0, 4, 4'd4, 4'd7};
        tbl[6] = '{16'h0000, 0, 4'd0, 4'd0};

        rst = 1'b1; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_zero", zero_mask, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        step();

        // directed table at full throughput: beats must be back-to-back
        foreach (tbl[i]) begin
            run_mask(tbl[i].mask, 100, nb, fi, la, cyc);
            chk("tbl_beats", nb, tbl[i].beats);
            chk("tbl_first", fi, tbl[i].first);
            chk("tbl_final", la, tbl[i].final_idx);
            chk("tbl_cycles", cyc, tbl[i].beats);
        end

        // backpressure: idx 4 held for three stalled cycles
        in_valid = 1'b1; in_mask = 16'h0110;
        step();
        in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_idx", out_idx, 4);
            chk("stall_last", out_last, 0);
            step();
        end
        out_ready = 1'b1;
        chk("bp_idx4", out_idx, 4);
        step();
        chk("bp_idx8", out_idx, 8);
        chk("bp_last8", out_last, 1);
        chk("bp_valid8", out_valid, 1);
        step();
        out_ready = 1'b0;
        chk("bp_done", in_ready, 1);

        // reset mid-scan discards remaining bits
        in_valid = 1'b1; in_mask = 16'h00F0;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("mid_idx4", out_idx, 4);
        step();
        chk("mid_idx5", out_idx, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        step();
        chk("mid_rst_stay", out_valid, 0);
        run_mask(16'h0002, 100, nb, fi, la, cyc);
        chk("post_rst_beats", nb, 1);
        chk("post_rst_idx", la, 1);

        // random masks with random backpressure
        for (int t = 0; t < 150; t++) begin
            m = $urandom;
            case ($urandom_range(5))
                0: m = 16'h0;
                1: m = 16'h1 << $urandom_range(15);
                2: m = m & 16'($urandom);
                default: ;
            endcase
            run_mask(m, 20 + $urandom_range(80), nb, fi, la, cyc);
            chk("rnd_beats", nb, $countones(m));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
